// File: rtl/toggle_sync_sched.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_sync_sched
//  Brief    : Source-domain scheduler for a shared toggle-synchronizer channel.
//             Sticky per-requester pending flags, round-robin issue, GAP spacing.
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_sync_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int GAP   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic             pulse_out_o,
  output logic [ID_W-1:0]  id_out_o,
  output logic [N_REQ-1:0] pend_o,
  output logic             busy_o,
  output logic [7:0]       merge_cnt_o
);

  localparam int GAP_W = $clog2(GAP + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic               pulse_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [N_REQ-1:0]   pend_q;
  logic [N_REQ-1:0]   pend_d;
  logic [7:0]         merge_cnt_q;
  logic [7:0]         merge_cnt_d;

  logic               w_issue;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_idx;
  logic [N_REQ-1:0]   w_grant_oh;
  logic [15:0]        w_merge_sum;
  logic [15:0]        w_merge_tot;
  int                 w_j;
  logic [ID_W-1:0]    w_idx;

  // Round-robin search over registered pending flags, starting at rr_ptr.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_j         = 0;
    w_idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(rr_ptr_q) + k;
      if (w_j >= N_REQ) begin
        w_j = w_j - N_REQ;
      end
      w_idx = ID_W'(w_j);
      if (!w_grant_vld && pend_q[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  assign w_issue = (state_q == S_IDLE) && en_i && w_grant_vld;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
      assign w_grant_oh[gi] = w_issue && (w_grant_idx == ID_W'(gi));
    end
  endgenerate

  // A request landing on an already-pending, ungranted flag is a lost event.
  always_comb begin
    pend_d      = pend_q;
    w_merge_sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_oh[i]) begin
        pend_d[i] = req_i[i];
      end else begin
        pend_d[i] = pend_q[i] | req_i[i];
      end
      if (req_i[i] && pend_q[i] && !w_grant_oh[i]) begin
        w_merge_sum = w_merge_sum + 16'd1;
      end
    end
    w_merge_tot = {8'd0, merge_cnt_q} + w_merge_sum;
    merge_cnt_d = (w_merge_tot > 16'd255) ? 8'hFF : w_merge_tot[7:0];
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_issue) begin
      rr_ptr_d = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pulse_q     <= 1'b0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      pend_q      <= '0;
      merge_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      merge_cnt_q <= merge_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      case (state_q)
        S_IDLE: begin
          if (w_issue) begin
            pulse_q   <= 1'b1;
            id_q      <= w_grant_idx;
            gap_cnt_q <= GAP_W'(GAP - 1);
            state_q   <= S_HOLD;
          end else begin
            pulse_q   <= 1'b0;
          end
        end
        S_HOLD: begin
          pulse_q   <= 1'b0;
          gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          pulse_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pulse_out_o = pulse_q;
  assign id_out_o    = id_q;
  assign pend_o      = pend_q;
  assign busy_o      = (state_q != S_IDLE) | (|pend_q);
  assign merge_cnt_o = merge_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_sync_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_sync_sched
//  Brief    : Directed scenarios plus randomized traffic against a timestamp model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_sync_sched;

  localparam int N   = 4;
  localparam int GAP = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] req;
  logic         pulse_out;
  logic [1:0]   id_out;
  logic [N-1:0] pend;
  logic         busy;
  logic [7:0]   merge_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: pulse issue times are tracked as absolute cycle stamps.
  bit m_pend[N];
  int m_rr, m_last, m_cyc, m_id, m_merge;
  bit m_pulse, m_busy;

  toggle_sync_sched #(.N_REQ(N), .ID_W(2), .GAP(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .req_i       (req),
    .pulse_out_o (pulse_out),
    .id_out_o    (id_out),
    .pend_o      (pend),
    .busy_o      (busy),
    .merge_cnt_o (merge_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [N-1:0] q);
    int g;
    bit any;
    bit nxt[N];
    m_cyc++;
    if (r) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_rr = 0; m_last = -1000; m_id = 0; m_merge = 0; m_pulse = 0; m_busy = 0;
      return;
    end
    any = 0;
    for (int i = 0; i < N; i++) any |= m_pend[i];
    g = -1;
    if (e && any && (m_cyc - m_last >= GAP)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (q[i] && m_pend[i] && g != i && m_merge < 255) m_merge++;
      nxt[i] = (g == i) ? q[i] : (m_pend[i] | q[i]);
    end
    any = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = nxt[i];
      any |= nxt[i];
    end
    m_pulse = (g >= 0);
    if (g >= 0) begin
      m_id = g; m_rr = (g + 1) % N; m_last = m_cyc;
    end
    m_busy = (m_cyc - m_last < GAP - 1) || any;
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] q);
    logic [N-1:0] mp;
    rst = r; en = e; req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
    for (int i = 0; i < N; i++) mp[i] = m_pend[i];
    chk("pulse", {31'd0, pulse_out}, {31'd0, m_pulse});
    chk("id", {30'd0, id_out}, m_id);
    chk("pend", {28'd0, pend}, {28'd0, mp});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("merge", {24'd0, merge_cnt}, m_merge);
  endtask

  task automatic scn_in(input int s, input int t, output logic r, output logic e,
                        output logic [N-1:0] q);
    r = 0; e = 1; q = '0;
    case (s)
      2: if (t == 10) q = 4'b0100;
      3: if (t == 10) q = 4'hF;
      4: if (t == 10) q = 4'b0010; else if (t == 14) q = 4'b0101;
      5: if (t == 10) q = 4'b0001; else if (t == 13 || t == 15) q = 4'b0010;
      6: begin e = !(t >= 8 && t < 20); if (t == 10) q = 4'b1000; end
      7: begin if (t == 10) q = 4'hF; if (t == 20) r = 1; end
      default: ;
    endcase
  endtask

  // Expected issue cycle -> id for each directed scenario; -1 means no pulse.
  function automatic int exp_id(input int s, input int k);
    case (s)
      2: return (k == 12) ? 2 : -1;
      3: return (k == 12) ? 0 : (k == 18) ? 1 : (k == 24) ? 2 : (k == 30) ? 3 : -1;
      4: return (k == 12) ? 1 : (k == 18) ? 2 : (k == 24) ? 0 : -1;
      5: return (k == 12) ? 0 : (k == 18) ? 1 : -1;
      6: return (k == 21) ? 3 : -1;
      7: return (k == 12) ? 0 : (k == 18) ? 1 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic run_scn(input int s);
    logic r, e;
    logic [N-1:0] q;
    int ei;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF);
    chk("rst_pulse", {31'd0, pulse_out}, 32'd0);
    chk("rst_id", {30'd0, id_out}, 32'd0);
    chk("rst_pend", {28'd0, pend}, 32'd0);
    chk("rst_merge", {24'd0, merge_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      scn_in(s, k - 1, r, e, q);
      step(r, e, q);
      ei = exp_id(s, k);
      chk($sformatf("s%0d_pulse_k%0d", s, k), {31'd0, pulse_out}, (ei >= 0) ? 32'd1 : 32'd0);
      if (ei >= 0) chk($sformatf("s%0d_id_k%0d", s, k), {30'd0, id_out}, ei);
      if (s == 2) chk($sformatf("s2_busy_k%0d", k), {31'd0, busy},
                      (k >= 11 && k <= 16) ? 32'd1 : 32'd0);
      if (s == 7 && k == 21) begin
        chk("s7_pend", {28'd0, pend}, 32'd0);
        chk("s7_merge", {24'd0, merge_cnt}, 32'd0);
      end
    end
    if (s == 3) chk("s3_merge", {24'd0, merge_cnt}, 32'd0);
    if (s == 5) chk("s5_merge", {24'd0, merge_cnt}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0;
    m_cyc = 0; m_last = -1000; m_rr = 0; m_id = 0; m_merge = 0;
    m_pulse = 0; m_busy = 0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;

    for (int s = 2; s <= 7; s++) run_scn(s);

    // Random traffic with occasional enable drops and reset.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 2) == 0) ? N'($urandom) : '0);
    end

    // Saturation of the merge counter, then drain.
    for (int c = 0; c < 120; c++) step(1'b0, 1'b0, 4'hF);
    chk("merge_sat", {24'd0, merge_cnt}, 32'd255);
    for (int c = 0; c < 60; c++) step(1'b0, 1'b1, '0);
    chk("drain_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
